hs_io_port: RTL and testbench

- Byte I/O peripheral that sits directly on the processor's handshake I/O pins: it consumes bus_out/hs_out and produces bus_in/hs_in for the RIN and R_OUT path.
- It decouples the processor's 4-phase handshake from an external device's valid/ready byte streams.
- Buffering uses one TX FIFO (CPU -> device) and one RX FIFO (device -> CPU), so IN/OUT instructions only stall when a FIFO is full or empty.

---
 rtl/hs_io_pkg.sv | 19 +
 rtl/hs_io_port_sync_fifo.sv | 79 +++++++
 rtl/hs_io_port.sv | 123 ++++++++++++
 tb/tb_hs_io_port.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_io_pkg.sv
// -----------------------------------------------------------------------------
// hs_io_pkg
// Shared definitions for the handshake byte I/O port.
//   state_e        : handshake FSM encoding (IDLE=0, ACK=1)
//   BYTE_W         : width of every byte path
//   DEFAULT_DEPTH  : default entries per FIFO
// Optional feature macro used by the port: HS_IO_PORT_LOOPBACK_EN.
// -----------------------------------------------------------------------------
package hs_io_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

endpackage

// File: rtl/hs_io_port_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy count.
//   g_clk, g_clr : clock and synchronous active-high clear
//   push, push_data : write request / data (honoured when not full, or when
//                     full and a pop happens on the same edge)
//   pop          : read request, honoured when not empty
//   head         : oldest entry (valid while !empty)
//   full, empty  : derived from the count
//   count        : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only because the same edge frees a slot.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred;
    // comb logic uses blocking '=', sequential state uses non-blocking '<='.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are PTR_W bits wide, so the increment wraps modulo DEPTH.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not cleared; the pointers and
  // count alone decide which entries are valid.
  always_ff @(posedge g_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hs_io_port.sv
// -----------------------------------------------------------------------------
// hs_io_port
// Bridges the processor's 4-phase hs_out/hs_in handshake to device-side
// valid/ready byte streams through a TX FIFO (CPU->device) and an RX FIFO
// (device->CPU).
//   g_clk, g_clr          : clock, synchronous active-high clear
//   bus_out, hs_out, cpu_rd : processor request (cpu_rd=1 IN, 0 OUT)
//   bus_in, hs_in         : byte returned on IN, acknowledge
//   dev_tx_*              : TX stream to the device (head of TX FIFO)
//   dev_rx_*              : RX stream from the device
//   tx_count, rx_count    : FIFO occupancies
// Optional macro HS_IO_PORT_LOOPBACK_EN adds input 'loopback': when high the
// TX head is moved straight into the RX FIFO and both device streams idle.
// -----------------------------------------------------------------------------
module hs_io_port
  import hs_io_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              g_clk,
  input  logic              g_clr,
`ifdef HS_IO_PORT_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic [BYTE_W-1:0] bus_out,
  input  logic              hs_out,
  input  logic              cpu_rd,
  output logic [BYTE_W-1:0] bus_in,
  output logic              hs_in,
  output logic [BYTE_W-1:0] dev_tx_data,
  output logic              dev_tx_valid,
  input  logic              dev_tx_ready,
  input  logic [BYTE_W-1:0] dev_rx_data,
  input  logic              dev_rx_valid,
  output logic              dev_rx_ready,
  output logic [PTR_W:0]    tx_count,
  output logic [PTR_W:0]    rx_count
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] bus_in_q, bus_in_d;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [BYTE_W-1:0] tx_head, rx_head, rx_push_data;

  // State register.
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_q  <= IDLE;
      bus_in_q <= '0;
    end else begin
      state_q  <= state_d;
      bus_in_q <= bus_in_d;
    end
  end

  // Next state: a request is accepted only from IDLE, so hs_out must be seen
  // low (ACK -> IDLE) before the next one is recognised.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (hs_out && (cpu_rd ? !rx_empty : !tx_full)) state_d = ACK;
      ACK:  if (!hs_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: exactly one FIFO push/pop on the accepting edge. The TX full
  // check ignores a same-edge device pop.
  always_comb begin
    tx_push  = (state_q == IDLE) & hs_out & ~cpu_rd & ~tx_full;
    rx_pop   = (state_q == IDLE) & hs_out &  cpu_rd & ~rx_empty;
    bus_in_d = rx_pop ? rx_head : bus_in_q;
  end

  assign hs_in       = (state_q == ACK);
  assign bus_in      = bus_in_q;
  assign dev_tx_data = tx_head;

`ifdef HS_IO_PORT_LOOPBACK_EN
  logic lb_xfer;
  assign lb_xfer      = loopback & ~tx_empty & ~rx_full;
  assign tx_pop       = loopback ? lb_xfer : (~tx_empty & dev_tx_ready);
  assign rx_push      = loopback ? lb_xfer : (dev_rx_valid & dev_rx_ready);
  assign rx_push_data = loopback ? tx_head : dev_rx_data;
  assign dev_tx_valid = ~tx_empty & ~loopback;
  assign dev_rx_ready = ~loopback & (~rx_full | rx_pop);
`else
  assign tx_pop       = ~tx_empty & dev_tx_ready;
  assign rx_push      = dev_rx_valid & dev_rx_ready;
  assign rx_push_data = dev_rx_data;
  assign dev_tx_valid = ~tx_empty;
  // A full RX still accepts a device byte on the edge the processor pops one.
  assign dev_rx_ready = ~rx_full | rx_pop;
`endif

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
    .g_clk     (g_clk),
    .g_clr     (g_clr),
    .push      (tx_push),
    .push_data (bus_out),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .g_clk     (g_clk),
    .g_clr     (g_clr),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

endmodule

// File: tb/tb_hs_io_port.sv
// -----------------------------------------------------------------------------
// tb_hs_io_port
// Directed scenarios plus a randomized run, each checked against a
// transaction-level model built from two byte queues and an ack flag.
// Inputs change on the falling edge; registered outputs are read on the next
// falling edge.
// -----------------------------------------------------------------------------
module tb_hs_io_port;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             g_clk = 1'b0;
  logic             g_clr, hs_out, cpu_rd, dev_tx_ready, dev_rx_valid;
  logic [7:0]       bus_out, dev_rx_data;
  logic [7:0]       bus_in, dev_tx_data;
  logic             hs_in, dev_tx_valid, dev_rx_ready;
  logic [PTR_W:0]   tx_count, rx_count;
`ifdef HS_IO_PORT_LOOPBACK_EN
  logic             loopback = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         m_ack = 1'b0;
  logic [7:0] m_bus_in = 8'h00;

  always #5 g_clk = ~g_clk;

  hs_io_port #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .g_clk        (g_clk),
    .g_clr        (g_clr),
`ifdef HS_IO_PORT_LOOPBACK_EN
    .loopback     (loopback),
`endif
    .bus_out      (bus_out),
    .hs_out       (hs_out),
    .cpu_rd       (cpu_rd),
    .bus_in       (bus_in),
    .hs_in        (hs_in),
    .dev_tx_data  (dev_tx_data),
    .dev_tx_valid (dev_tx_valid),
    .dev_tx_ready (dev_tx_ready),
    .dev_rx_data  (dev_rx_data),
    .dev_rx_valid (dev_rx_valid),
    .dev_rx_ready (dev_rx_ready),
    .tx_count     (tx_count),
    .rx_count     (rx_count)
  );

  // One clock edge of the model, using the inputs held across the edge.
  task automatic model_edge();
    int         txn, rxn;
    bit         lb, cpu_push, cpu_pop, tx_pop, rx_push;
    logic [7:0] rx_in;
    txn = tx_q.size();
    rxn = rx_q.size();
    if (g_clr) begin
      tx_q.delete();
      rx_q.delete();
      m_ack    = 1'b0;
      m_bus_in = 8'h00;
      return;
    end
    lb = 1'b0;
`ifdef HS_IO_PORT_LOOPBACK_EN
    lb = loopback;
`endif
    cpu_push = !m_ack && hs_out && !cpu_rd && (txn < DEPTH);
    cpu_pop  = !m_ack && hs_out &&  cpu_rd && (rxn > 0);
    if (lb) begin
      tx_pop  = (txn > 0) && (rxn < DEPTH);
      rx_push = tx_pop;
      rx_in   = (txn > 0) ? tx_q[0] : 8'h00;
    end else begin
      tx_pop  = (txn > 0) && dev_tx_ready;
      rx_push = dev_rx_valid && ((rxn < DEPTH) || cpu_pop);
      rx_in   = dev_rx_data;
    end
    if (cpu_pop)  m_bus_in = rx_q.pop_front();
    if (rx_push)  rx_q.push_back(rx_in);
    if (tx_pop)   void'(tx_q.pop_front());
    if (cpu_push) tx_q.push_back(bus_out);
    if (cpu_push || cpu_pop)  m_ack = 1'b1;
    else if (m_ack && !hs_out) m_ack = 1'b0;
  endtask

  // Advance one cycle: edge (DUT + model), then return on the falling edge.
  task automatic tick();
    @(posedge g_clk);
    model_edge();
    @(negedge g_clk);
  endtask

  // Full processor handshake; acked reports whether hs_in rose within budget.
  task automatic cpu_xfer(input bit rd, input logic [7:0] data, input int budget,
                          output bit acked);
    hs_out  = 1'b1;
    cpu_rd  = rd;
    bus_out = data;
    acked   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (hs_in === 1'b1) begin acked = 1'b1; break; end
    end
    hs_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!m_ack) break;
    end
  endtask

  task automatic test_reset();
    g_clr = 1'b1; hs_out = 1'b0; cpu_rd = 1'b0; bus_out = 8'h00;
    dev_tx_ready = 1'b0; dev_rx_valid = 1'b0; dev_rx_data = 8'h00;
    tick();
    tick();
    g_clr = 1'b0;
    #1;
    n_cmp++; if (hs_in !== 1'b0)        begin n_err++; $display("FAIL reset_hs_in got %b want 0", hs_in); end
    n_cmp++; if (bus_in !== 8'h00)      begin n_err++; $display("FAIL reset_bus_in got %h want 00", bus_in); end
    n_cmp++; if (tx_count !== 3'd0)     begin n_err++; $display("FAIL reset_tx_count got %0d want 0", tx_count); end
    n_cmp++; if (rx_count !== 3'd0)     begin n_err++; $display("FAIL reset_rx_count got %0d want 0", rx_count); end
    n_cmp++; if (dev_tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", dev_tx_valid); end
    n_cmp++; if (dev_rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready got %b want 1", dev_rx_ready); end
  endtask

  task automatic test_out_single();
    hs_out = 1'b1; cpu_rd = 1'b0; bus_out = 8'hA5;
    #1;
    n_cmp++; if (hs_in !== 1'b0) begin n_err++; $display("FAIL out_hs_in_early got %b want 0", hs_in); end
    tick();
    n_cmp++; if (hs_in !== 1'b1)        begin n_err++; $display("FAIL out_hs_in_rise got %b want 1", hs_in); end
    n_cmp++; if (tx_count !== 3'd1)     begin n_err++; $display("FAIL out_tx_count got %0d want 1", tx_count); end
    n_cmp++; if (dev_tx_valid !== 1'b1) begin n_err++; $display("FAIL out_tx_valid got %b want 1", dev_tx_valid); end
    n_cmp++; if (dev_tx_data !== 8'hA5) begin n_err++; $display("FAIL out_tx_data got %h want a5", dev_tx_data); end
    tick();
    n_cmp++; if (hs_in !== 1'b1) begin n_err++; $display("FAIL out_hs_in_hold got %b want 1", hs_in); end
    hs_out = 1'b0;
    tick();
    n_cmp++; if (hs_in !== 1'b0) begin n_err++; $display("FAIL out_hs_in_fall got %b want 0", hs_in); end
    dev_tx_ready = 1'b1;
    tick();
    dev_tx_ready = 1'b0;
    n_cmp++; if (tx_count !== 3'd0) begin n_err++; $display("FAIL out_drain got %0d want 0", tx_count); end
  endtask

  task automatic test_tx_stall();
    bit acked;
    for (int k = 0; k < 4; k++) begin
      cpu_xfer(1'b0, 8'h10 + 8'(k), 5, acked);
      n_cmp++; if (acked !== 1'b1) begin n_err++; $display("FAIL stall_ack%0d got %b want 1", k, acked); end
    end
    hs_out = 1'b1; cpu_rd = 1'b0; bus_out = 8'h14;
    repeat (3) tick();
    n_cmp++; if (hs_in !== 1'b0)    begin n_err++; $display("FAIL stall_hold got %b want 0", hs_in); end
    n_cmp++; if (tx_count !== 3'd4) begin n_err++; $display("FAIL stall_full got %0d want 4", tx_count); end
    dev_tx_ready = 1'b1;
    tick();
    dev_tx_ready = 1'b0;
    // The push waits one more edge: fullness is judged before the pop.
    n_cmp++; if (hs_in !== 1'b0)    begin n_err++; $display("FAIL stall_same_edge got %b want 0", hs_in); end
    n_cmp++; if (tx_count !== 3'd3) begin n_err++; $display("FAIL stall_pop got %0d want 3", tx_count); end
    tick();
    n_cmp++; if (hs_in !== 1'b1)    begin n_err++; $display("FAIL stall_ack5 got %b want 1", hs_in); end
    hs_out = 1'b0;
    tick();
    dev_tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++;
      if (dev_tx_data !== 8'h10 + 8'(k) || dev_tx_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_order%0d got %h/%b want %h/1", k, dev_tx_data, dev_tx_valid, 8'h10 + 8'(k));
      end
      tick();
    end
    dev_tx_ready = 1'b0;
    n_cmp++; if (tx_count !== 3'd0) begin n_err++; $display("FAIL stall_empty got %0d want 0", tx_count); end
  endtask

  task automatic test_rx_empty_in();
    hs_out = 1'b1; cpu_rd = 1'b1;
    repeat (3) tick();
    n_cmp++; if (hs_in !== 1'b0) begin n_err++; $display("FAIL rxe_stall got %b want 0", hs_in); end
    dev_rx_valid = 1'b1; dev_rx_data = 8'h3C;
    #1;
    n_cmp++; if (dev_rx_ready !== 1'b1) begin n_err++; $display("FAIL rxe_ready got %b want 1", dev_rx_ready); end
    tick();
    dev_rx_valid = 1'b0;
    n_cmp++; if (rx_count !== 3'd1) begin n_err++; $display("FAIL rxe_fill got %0d want 1", rx_count); end
    tick();
    n_cmp++; if (hs_in !== 1'b1)    begin n_err++; $display("FAIL rxe_ack got %b want 1", hs_in); end
    n_cmp++; if (bus_in !== 8'h3C)  begin n_err++; $display("FAIL rxe_data got %h want 3c", bus_in); end
    n_cmp++; if (rx_count !== 3'd0) begin n_err++; $display("FAIL rxe_count got %0d want 0", rx_count); end
    hs_out = 1'b0;
    tick();
    n_cmp++; if (hs_in !== 1'b0 || bus_in !== 8'h3C) begin
      n_err++; $display("FAIL rxe_release got %b/%h want 0/3c", hs_in, bus_in);
    end
  endtask

  task automatic test_rx_full();
    bit acked;
    dev_rx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dev_rx_data = 8'h40 + 8'(k);
      tick();
    end
    dev_rx_data = 8'h44;
    #1;
    n_cmp++; if (rx_count !== 3'd4)     begin n_err++; $display("FAIL rxf_full got %0d want 4", rx_count); end
    n_cmp++; if (dev_rx_ready !== 1'b0) begin n_err++; $display("FAIL rxf_ready_lo got %b want 0", dev_rx_ready); end
    tick();
    hs_out = 1'b1; cpu_rd = 1'b1;
    #1;
    n_cmp++; if (dev_rx_ready !== 1'b1) begin n_err++; $display("FAIL rxf_ready_pop got %b want 1", dev_rx_ready); end
    tick();
    dev_rx_valid = 1'b0;
    n_cmp++; if (rx_count !== 3'd4) begin n_err++; $display("FAIL rxf_same_edge got %0d want 4", rx_count); end
    n_cmp++; if (bus_in !== 8'h40)  begin n_err++; $display("FAIL rxf_first got %h want 40", bus_in); end
    hs_out = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      cpu_xfer(1'b1, 8'h00, 5, acked);
      n_cmp++;
      if (acked !== 1'b1 || bus_in !== 8'h40 + 8'(k)) begin
        n_err++; $display("FAIL rxf_order%0d got %b/%h want 1/%h", k, acked, bus_in, 8'h40 + 8'(k));
      end
    end
    n_cmp++; if (rx_count !== 3'd0) begin n_err++; $display("FAIL rxf_empty got %0d want 0", rx_count); end
  endtask

  task automatic test_reset_mid_ack();
    bit acked;
    cpu_xfer(1'b0, 8'h55, 5, acked);
    hs_out = 1'b1; cpu_rd = 1'b0; bus_out = 8'h66;
    tick();
    n_cmp++; if (hs_in !== 1'b1 || tx_count !== 3'd2) begin
      n_err++; $display("FAIL clr_setup got %b/%0d want 1/2", hs_in, tx_count);
    end
    g_clr = 1'b1;
    tick();
    g_clr = 1'b0; hs_out = 1'b0;
    n_cmp++; if (hs_in !== 1'b0)        begin n_err++; $display("FAIL clr_hs_in got %b want 0", hs_in); end
    n_cmp++; if (tx_count !== 3'd0)     begin n_err++; $display("FAIL clr_tx_count got %0d want 0", tx_count); end
    n_cmp++; if (dev_tx_valid !== 1'b0) begin n_err++; $display("FAIL clr_tx_valid got %b want 0", dev_tx_valid); end
    n_cmp++; if (bus_in !== 8'h00)      begin n_err++; $display("FAIL clr_bus_in got %h want 00", bus_in); end
    tick();
    n_cmp++; if (hs_in !== 1'b0) begin n_err++; $display("FAIL clr_idle got %b want 0", hs_in); end
  endtask

  task automatic test_random();
    logic [PTR_W:0] exp_tx, exp_rx;
    bit             exp_rdy;
    for (int c = 0; c < 600; c++) begin
      // Processor: start a request now and then, release once acknowledged.
      if (!hs_out && !m_ack && $urandom_range(0, 2) == 0) begin
        hs_out  = 1'b1;
        cpu_rd  = 1'($urandom_range(0, 1));
        bus_out = 8'($urandom);
      end else if (hs_out && m_ack && $urandom_range(0, 1) == 0) begin
        hs_out = 1'b0;
      end
      dev_tx_ready = ($urandom_range(0, 2) == 0);
      dev_rx_valid = ($urandom_range(0, 2) == 0);
      dev_rx_data  = 8'($urandom);
      #1;
      exp_rdy = (rx_q.size() < DEPTH) || (!m_ack && hs_out && cpu_rd && rx_q.size() > 0);
      n_cmp++; if (dev_rx_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_rx_ready c%0d got %b want %b", c, dev_rx_ready, exp_rdy); end
      tick();
      exp_tx = (PTR_W + 1)'(tx_q.size());
      exp_rx = (PTR_W + 1)'(rx_q.size());
      n_cmp++; if (hs_in !== m_ack)       begin n_err++; $display("FAIL rnd_hs_in c%0d got %b want %b", c, hs_in, m_ack); end
      n_cmp++; if (bus_in !== m_bus_in)   begin n_err++; $display("FAIL rnd_bus_in c%0d got %h want %h", c, bus_in, m_bus_in); end
      n_cmp++; if (tx_count !== exp_tx)   begin n_err++; $display("FAIL rnd_tx_count c%0d got %0d want %0d", c, tx_count, exp_tx); end
      n_cmp++; if (rx_count !== exp_rx)   begin n_err++; $display("FAIL rnd_rx_count c%0d got %0d want %0d", c, rx_count, exp_rx); end
      n_cmp++; if (dev_tx_valid !== (tx_q.size() > 0)) begin
        n_err++; $display("FAIL rnd_tx_valid c%0d got %b want %b", c, dev_tx_valid, tx_q.size() > 0);
      end
      if (tx_q.size() > 0) begin
        n_cmp++; if (dev_tx_data !== tx_q[0]) begin n_err++; $display("FAIL rnd_tx_data c%0d got %h want %h", c, dev_tx_data, tx_q[0]); end
      end
    end
    hs_out = 1'b0; dev_tx_ready = 1'b0; dev_rx_valid = 1'b0;
    repeat (2) tick();
  endtask

`ifdef HS_IO_PORT_LOOPBACK_EN
  task automatic test_loopback();
    bit acked;
    g_clr = 1'b1;
    tick();
    g_clr = 1'b0;
    loopback = 1'b1;
    dev_tx_ready = 1'b1; dev_rx_valid = 1'b1;
    cpu_xfer(1'b0, 8'h11, 5, acked);
    n_cmp++; if (dev_tx_valid !== 1'b0 || dev_rx_ready !== 1'b0) begin
      n_err++; $display("FAIL lb_idle1 got %b/%b want 0/0", dev_tx_valid, dev_rx_ready);
    end
    cpu_xfer(1'b0, 8'h22, 5, acked);
    n_cmp++; if (dev_tx_valid !== 1'b0) begin n_err++; $display("FAIL lb_idle2 got %b want 0", dev_tx_valid); end
    tick();
    cpu_xfer(1'b1, 8'h00, 8, acked);
    n_cmp++; if (acked !== 1'b1 || bus_in !== 8'h11) begin n_err++; $display("FAIL lb_in1 got %b/%h want 1/11", acked, bus_in); end
    cpu_xfer(1'b1, 8'h00, 8, acked);
    n_cmp++; if (acked !== 1'b1 || bus_in !== 8'h22) begin n_err++; $display("FAIL lb_in2 got %b/%h want 1/22", acked, bus_in); end
    n_cmp++; if (dev_tx_valid !== 1'b0) begin n_err++; $display("FAIL lb_idle3 got %b want 0", dev_tx_valid); end
    loopback = 1'b0; dev_tx_ready = 1'b0; dev_rx_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    g_clr = 1'b1; hs_out = 1'b0; cpu_rd = 1'b0; bus_out = 8'h00;
    dev_tx_ready = 1'b0; dev_rx_valid = 1'b0; dev_rx_data = 8'h00;
    @(negedge g_clk);
    test_reset();
    test_out_single();
    test_tx_stall();
    test_rx_empty_in();
    test_rx_full();
    test_reset_mid_ack();
    test_random();
`ifdef HS_IO_PORT_LOOPBACK_EN
    test_loopback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
